// File: rtl/deserializador_rx.sv
// -----------------------------------------------------------------------------
// deserializador_rx
//   Serial-to-parallel receiver with comma-based link lock.
//   Bytes arrive MSB first, one bit per clk_32f cycle. Byte boundaries are
//   fixed by reset release: the first non-reset edge samples bit 7 of byte 0.
//   The receiver stays in SEARCH until BC_LOCK consecutive COM bytes are
//   seen, then stays ACTIVE until reset, presenting every non-COM byte.
//
// Parameters
//   COM       comma/idle symbol sent when no lane data is valid
//   BC_LOCK   consecutive COM bytes required to declare the link active (1..7)
//
// Ports
//   clk_32f      in   bit clock, all state updates on its rising edge
//   reset        in   synchronous active-high reset
//   data_in      in   serial bit stream, MSB first
//   data_out     out  last recovered non-COM byte
//   valid_out    out  data_out carries a data byte for this byte period
//   active       out  link locked
//   byte_strobe  out  one-cycle pulse after each byte-completing edge
// -----------------------------------------------------------------------------
module deserializador_rx #(
  parameter logic [7:0]  COM     = 8'hBC,
  parameter int unsigned BC_LOCK = 4
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       active,
  output logic       byte_strobe
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 3;

  localparam logic [CNT_W-1:0] LAST_BIT = 3'(BYTE_W - 1);
  // One bit wider than bc_cnt so the increment never wraps before the compare.
  localparam logic [CNT_W:0]   LOCK_N   = 4'(BC_LOCK);
  localparam logic [CNT_W-1:0] LOCK_SAT = 3'(BC_LOCK);

  typedef enum logic {
    SEARCH = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  state_t              state;
  logic [CNT_W-1:0]    bit_cnt;
  logic [CNT_W-1:0]    bc_cnt;
  // Only the seven most recent bits are ever needed: the eighth comes
  // straight from data_in on the completing edge.
  logic [BYTE_W-2:0]   shift;

  logic [BYTE_W-1:0]   byte_c;
  logic                complete_c;
  logic [CNT_W:0]      bc_next_c;
  logic                lock_c;

  // Byte assembly and lock-threshold decode.
  always_comb begin
    byte_c     = {shift, data_in};
    complete_c = (bit_cnt == LAST_BIT);
    bc_next_c  = {1'b0, bc_cnt} + 4'd1;
    lock_c     = (bc_next_c >= LOCK_N);
  end

  // Bit alignment, lock FSM and registered outputs.
  always_ff @(posedge clk_32f) begin
    if (reset) begin
      state       <= SEARCH;
      bit_cnt     <= '0;
      bc_cnt      <= '0;
      shift       <= '0;
      data_out    <= '0;
      valid_out   <= 1'b0;
      active      <= 1'b0;
      byte_strobe <= 1'b0;
    end else begin
      bit_cnt     <= bit_cnt + 3'd1;
      shift       <= byte_c[BYTE_W-2:0];
      byte_strobe <= complete_c;

      if (complete_c) begin
        case (state)
          SEARCH: begin
            // The COM byte that completes lock never produces valid data.
            if (byte_c == COM) begin
              if (lock_c) begin
                state  <= ACTIVE;
                active <= 1'b1;
                bc_cnt <= LOCK_SAT;
              end else begin
                bc_cnt <= bc_next_c[CNT_W-1:0];
              end
            end else begin
              bc_cnt <= '0;
            end
          end

          ACTIVE: begin
            // COM marks an idle byte period: drop valid, keep the last data.
            if (byte_c != COM) begin
              data_out  <= byte_c;
              valid_out <= 1'b1;
            end else begin
              valid_out <= 1'b0;
            end
          end

          default: state <= SEARCH;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_deserializador_rx.sv
// -----------------------------------------------------------------------------
// tb_deserializador_rx
//   Directed bench for deserializador_rx. A table of {reset-before, byte,
//   expected active/valid/data} records drives whole bytes serially; every
//   edge inside a byte also checks that outputs hold and byte_strobe stays
//   low, and the completing edge checks the new values and the strobe.
//   Reset in the middle of a byte, reset on a completing edge and relock
//   are exercised by hand-written sequences.
// -----------------------------------------------------------------------------
module tb_deserializador_rx;

  logic       clk_32f;
  logic       reset;
  logic       data_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic       active;
  logic       byte_strobe;

  int checks;
  int failures;

  // Expected output state after the most recent completing edge.
  logic       cur_a;
  logic       cur_v;
  logic [7:0] cur_d;

  typedef struct {
    logic       do_reset;
    logic [7:0] b;
    logic       exp_active;
    logic       exp_valid;
    logic [7:0] exp_data;
  } vec_t;

  localparam int NV = 19;
  vec_t tbl[NV];

  deserializador_rx #(
    .COM     (8'hBC),
    .BC_LOCK (4)
  ) dut (
    .clk_32f     (clk_32f),
    .reset       (reset),
    .data_in     (data_in),
    .data_out    (data_out),
    .valid_out   (valid_out),
    .active      (active),
    .byte_strobe (byte_strobe)
  );

  initial clk_32f = 1'b0;
  always #5 clk_32f = ~clk_32f;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %02h expected %02h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Hold reset for n edges and check the cleared outputs.
  task automatic do_reset(input int n);
    reset   = 1'b1;
    data_in = 1'b0;
    repeat (n) @(posedge clk_32f);
    #1;
    chk("rst_data",   data_out, 8'h00);
    chk("rst_valid",  8'(valid_out), 8'h00);
    chk("rst_active", 8'(active), 8'h00);
    chk("rst_strobe", 8'(byte_strobe), 8'h00);
    reset = 1'b0;
    cur_a = 1'b0;
    cur_v = 1'b0;
    cur_d = 8'h00;
  endtask

  // Shift out bits [7:lo] of b; when lo==0 the byte completes and is checked.
  task automatic send_bits(input logic [7:0] b, input int lo,
                           input logic ea, input logic ev, input logic [7:0] ed);
    for (int i = 7; i >= lo; i--) begin
      data_in = b[i];
      @(posedge clk_32f);
      #1;
      if (i != 0) begin
        chk("hold_data",   data_out, cur_d);
        chk("hold_valid",  8'(valid_out), 8'(cur_v));
        chk("hold_active", 8'(active), 8'(cur_a));
        chk("strobe_low",  8'(byte_strobe), 8'h00);
      end else begin
        chk("byte_data",   data_out, ed);
        chk("byte_valid",  8'(valid_out), 8'(ev));
        chk("byte_active", 8'(active), 8'(ea));
        chk("strobe_high", 8'(byte_strobe), 8'h01);
        cur_a = ea;
        cur_v = ev;
        cur_d = ed;
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    data_in  = 1'b0;
    cur_a    = 1'b0;
    cur_v    = 1'b0;
    cur_d    = 8'h00;

    // Lock, data bytes, idle COM between data, zero byte as data.
    tbl[0]  = '{1'b1, 8'hBC, 1'b0, 1'b0, 8'h00};
    tbl[1]  = '{1'b0, 8'hBC, 1'b0, 1'b0, 8'h00};
    tbl[2]  = '{1'b0, 8'hBC, 1'b0, 1'b0, 8'h00};
    tbl[3]  = '{1'b0, 8'hBC, 1'b1, 1'b0, 8'h00};
    tbl[4]  = '{1'b0, 8'hA5, 1'b1, 1'b1, 8'hA5};
    tbl[5]  = '{1'b0, 8'h3C, 1'b1, 1'b1, 8'h3C};
    tbl[6]  = '{1'b0, 8'h11, 1'b1, 1'b1, 8'h11};
    tbl[7]  = '{1'b0, 8'hBC, 1'b1, 1'b0, 8'h11};
    tbl[8]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h00};
    tbl[9]  = '{1'b0, 8'hBC, 1'b1, 1'b0, 8'h00};
    // A non-COM byte inside the comma run restarts the lock count.
    tbl[10] = '{1'b1, 8'hBC, 1'b0, 1'b0, 8'h00};
    tbl[11] = '{1'b0, 8'hBC, 1'b0, 1'b0, 8'h00};
    tbl[12] = '{1'b0, 8'hBC, 1'b0, 1'b0, 8'h00};
    tbl[13] = '{1'b0, 8'h7E, 1'b0, 1'b0, 8'h00};
    tbl[14] = '{1'b0, 8'hBC, 1'b0, 1'b0, 8'h00};
    tbl[15] = '{1'b0, 8'hBC, 1'b0, 1'b0, 8'h00};
    tbl[16] = '{1'b0, 8'hBC, 1'b0, 1'b0, 8'h00};
    tbl[17] = '{1'b0, 8'hBC, 1'b1, 1'b0, 8'h00};
    tbl[18] = '{1'b0, 8'hBC, 1'b1, 1'b0, 8'h00};

    for (int k = 0; k < NV; k++) begin
      if (tbl[k].do_reset) do_reset(2);
      send_bits(tbl[k].b, 0, tbl[k].exp_active, tbl[k].exp_valid, tbl[k].exp_data);
    end

    // Reset half-way through a data byte, then relock and receive 0F.
    do_reset(2);
    for (int k = 0; k < 3; k++) send_bits(8'hBC, 0, 1'b0, 1'b0, 8'h00);
    send_bits(8'hBC, 0, 1'b1, 1'b0, 8'h00);
    send_bits(8'hF0, 4, 1'b0, 1'b0, 8'h00);
    do_reset(1);
    for (int k = 0; k < 3; k++) send_bits(8'hBC, 0, 1'b0, 1'b0, 8'h00);
    send_bits(8'hBC, 0, 1'b1, 1'b0, 8'h00);
    send_bits(8'h0F, 0, 1'b1, 1'b1, 8'h0F);

    // Reset on what would be a completing edge must win over the byte.
    send_bits(8'h55, 1, 1'b1, 1'b1, 8'h0F);
    do_reset(1);
    for (int k = 0; k < 3; k++) send_bits(8'hBC, 0, 1'b0, 1'b0, 8'h00);
    send_bits(8'hBC, 0, 1'b1, 1'b0, 8'h00);
    send_bits(8'hC3, 0, 1'b1, 1'b1, 8'hC3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
